hweval_stim_sig: RTL
====================

// Module: hweval_stim_sig
// PURPOSE
//  Parametrised hardware-evaluation harness core. Expands N_OPS narrow seeds into N_OPS
//  OP_W-bit pseudo-random operand buses, drives a pipelined DUT for a programmed number
//  of vectors, and compacts the DUT results into a RES_W-bit rotate-XOR signature.
//  Sits between a low-pin-count eval top and the arithmetic DUT, which is instantiated
//  in that top. Adds to the fixed two-channel LFSR scheme:
//   - start/done run control
//   - pipeline drain
//   - an observable signature
// PARAMETERS
//  N_OPS    2    number of operand channels
//  OP_W     512  operand width; multiple of 32, >= 32
//  SEED_W   16   per-channel seed width (fixed 16)
//  RES_W    11   DUT result width; >= 2
//  DUT_LAT  1    DUT latency in cycles from operand to result; >= 1
//  CNT_W    16   width of vector count and vector counter
// PORTS
//  clk          in   1             single clock; all state on rising edge
//  resetn       in   1             asynchronous active-low reset
//  start        in   1             run request; sampled only in IDLE or DONE
//  seeds        in   N_OPS*SEED_W  channel i seed = seeds[i*16 +: 16]
//  num_vectors  in   CNT_W         vectors to apply; latched on accepted start
//  dut_result   in   RES_W         DUT output
//  operands     out  N_OPS*OP_W    channel i operand = operands[i*OP_W +: OP_W]
//  busy         out  1             high in FILL, RUN, DRAIN
//  done         out  1             high in DONE only
//  vec_cnt      out  CNT_W         DUT results absorbed into signature this run
//  signature    out  RES_W         MISR value
// BEHAVIOUR
//  Reset: state=IDLE; operands, LFSRs, signature, vec_cnt, valid pipe = 0; busy=done=0.
//   Reset asserted at any point (including mid-RUN) aborts the run immediately.
//  FSM states: IDLE, FILL, RUN, DRAIN, DONE.
//  Accepted start (IDLE or DONE with start=1):
//   - per-channel LFSR <= {~seed_i, seed_i}; never all-zero
//   - signature <= 0, vec_cnt <= 0, num_vectors latched
//   - state <= FILL
//  start while busy is ignored. done stays high until the next accepted start.
//  LFSR: 32-bit Galois; poly x^32+x^22+x^2+x+1, mask 32'h8020_0003; shift right,
//   XOR mask when lsb=1.
//  Operand update, every FILL/RUN cycle, per channel:
//   - operand <= {operand[OP_W-33:0], lfsr}
//   - lfsr <= step(lfsr)
//  Operands and LFSRs are frozen in IDLE, DRAIN and DONE.
//  FILL lasts exactly OP_W/32 cycles so that operands are fully fresh, then goes to RUN.
//   If num_vectors = 0 it goes straight to DRAIN.
//  RUN lasts exactly num_vectors cycles. Each RUN cycle injects a 1 into a DUT_LAT-deep
//   valid shift pipe; other states inject 0.
//  DRAIN lasts exactly DUT_LAT cycles, then goes to DONE.
//  Signature absorb: on each edge where the valid pipe output is 1:
//   - signature <= {signature[RES_W-2:0], signature[RES_W-1]} ^ dut_result
//   - vec_cnt <= vec_cnt + 1
//   Hence the result for operands presented in RUN cycle t is sampled at end of cycle
//   t+DUT_LAT. The valid pipe is empty on entry to DONE.
//  vec_cnt wraps modulo 2^CNT_W; it cannot exceed num_vectors, so no wrap in practice.
// STRUCTURE
//  hweval_pkg:
//   - state enum hweval_state_e
//   - LFSR_POLY constant
//   - function lfsr32_step
//   - function misr_step(sig, res)
//  One sub-module hweval_lfsr_chan: one LFSR plus operand shift register, with
//   load/enable. Generate N_OPS copies. FSM, counters, valid pipe and MISR live in top.
// TESTING
//  1 Reset: hold resetn=0 -> busy=0, done=0, signature=0, vec_cnt=0, operands all 0.
//  2 Zero run: num_vectors=0, start -> busy for 16+DUT_LAT cycles (defaults),
//    then done=1, signature=0, vec_cnt=0.
//  3 Const result: dut_result=11'h001, num_vectors=11 -> done with signature=11'h7FF,
//    vec_cnt=11. Same with num_vectors=12 -> signature=11'h7FE.
//  4 Operand check: seeds={16'h0000,16'hFFFF} -> in the first RUN cycle,
//    operands match a reference model of 16 LFSR words per channel.
//    Channel1 initial LFSR = 32'hFFFF_0000; channel0 = 32'h0000_FFFF.
//  5 Latency: DUT_LAT=3, dut_result = pipelined XOR-fold model of operands ->
//    signature matches model. A start pulse during RUN is ignored.
//  6 Abort/restart: resetn=0 mid-RUN -> all outputs 0 next cycle. Restart from DONE ->
//    signature and vec_cnt cleared, identical seeds give an identical signature.

Source files
------------

// File: rtl/hweval_stim_sig_pkg.sv
// Shared types and helpers for the hardware-evaluation stimulus/signature core.
package hweval_stim_sig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } hweval_state_e;

  // Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // One Galois step: shift right, fold the taps in when the bit shifted out is 1.
  function automatic logic [31:0] lfsr32_step(input logic [31:0] lfsr);
    logic [31:0] nxt;
    nxt = lfsr >> 1;
    if (lfsr[0]) nxt = nxt ^ LFSR_POLY;
    return nxt;
  endfunction

  // Rotate-left-by-one then XOR the result word in, within the low w bits (w <= 32).
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] res,
                                            input int unsigned w);
    logic [31:0] mask;
    logic [31:0] rot;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    rot  = ((sig << 1) | ((sig & mask) >> (w - 1))) & mask;
    return rot ^ (res & mask);
  endfunction

endpackage

// File: rtl/hweval_stim_sig_if.sv
// Bus between the eval top and the stimulus/signature core: run control,
// seeds, status, the operand buses toward the DUT and the DUT result back.
interface hweval_stim_sig_if #(
  parameter int N_OPS  = 2,
  parameter int OP_W   = 512,
  parameter int SEED_W = 16,
  parameter int RES_W  = 11,
  parameter int CNT_W  = 16
);
  logic                      start;
  logic [N_OPS*SEED_W-1:0]   seeds;
  logic [CNT_W-1:0]          num_vectors;
  logic [RES_W-1:0]          dut_result;
  logic [N_OPS*OP_W-1:0]     operands;
  logic                      busy;
  logic                      done;
  logic [CNT_W-1:0]          vec_cnt;
  logic [RES_W-1:0]          signature;

  // Eval top side: issues runs, feeds back the DUT result.
  modport master (
    output start, seeds, num_vectors, dut_result,
    input  operands, busy, done, vec_cnt, signature
  );

  // Stimulus core side.
  modport slave (
    input  start, seeds, num_vectors, dut_result,
    output operands, busy, done, vec_cnt, signature
  );
endinterface

// File: rtl/hweval_stim_sig_lfsr_chan.sv
// One operand channel: a 32-bit Galois LFSR feeding a word-wide operand shift register.
module hweval_stim_sig_lfsr_chan
  import hweval_stim_sig_pkg::*;
#(
  parameter int OP_W   = 512,
  parameter int SEED_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              en,
  input  logic [SEED_W-1:0] seed,
  output logic [OP_W-1:0]   operand
);

  logic [31:0]     lfsr_p0;
  logic [OP_W-1:0] operand_p0;
  logic [OP_W-1:0] operand_shift;

  // The newest LFSR word enters at the low end; older words move up.
  generate
    if (OP_W == 32) begin : g_one_word
      assign operand_shift = lfsr_p0;
    end else begin : g_multi_word
      assign operand_shift = {operand_p0[OP_W-33:0], lfsr_p0};
    end
  endgenerate

  // Seed load makes the state {~seed, seed}, which can never be all-zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_p0    <= '0;
      operand_p0 <= '0;
    end else if (load) begin
      lfsr_p0    <= {~seed, seed};
    end else if (en) begin
      operand_p0 <= operand_shift;
      lfsr_p0    <= lfsr32_step(lfsr_p0);
    end
  end

  assign operand = operand_p0;

endmodule

// File: rtl/hweval_stim_sig.sv
// Stimulus/signature core: expands seeds into operand buses, runs a fixed number
// of vectors through an external pipelined DUT and compacts results into a MISR.
module hweval_stim_sig
  import hweval_stim_sig_pkg::*;
#(
  parameter int N_OPS   = 2,
  parameter int OP_W    = 512,
  parameter int SEED_W  = 16,
  parameter int RES_W   = 11,
  parameter int DUT_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                resetn,
  hweval_stim_sig_if.slave    bus
);

  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(OP_W / 32 - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DUT_LAT - 1);

  hweval_state_e           state_p0, state_nxt;
  logic [CNT_W-1:0]        cnt_p0, cnt_nxt;
  logic [CNT_W-1:0]        nv_p0;
  logic [CNT_W-1:0]        vec_p0;
  logic [RES_W-1:0]        sig_p0;
  logic [DUT_LAT-1:0]      vld_p0, vld_nxt;
  logic                    load, en, inject, absorb;
  logic [N_OPS*OP_W-1:0]   operands_w;

  // Operand channels
  generate
    for (genvar g = 0; g < N_OPS; g++) begin : g_chan
      hweval_stim_sig_lfsr_chan #(
        .OP_W   (OP_W),
        .SEED_W (SEED_W)
      ) u_chan (
        .clk     (clk),
        .resetn  (resetn),
        .load    (load),
        .en      (en),
        .seed    (bus.seeds[g*SEED_W +: SEED_W]),
        .operand (operands_w[g*OP_W +: OP_W])
      );
    end
  endgenerate

  // Next-state, phase counter and per-state strobes.
  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    load      = 1'b0;
    en        = 1'b0;
    inject    = 1'b0;
    unique case (state_p0)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        en = 1'b1;
        if (cnt_p0 == FILL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (nv_p0 == '0) ? ST_DRAIN : ST_RUN;
        end else begin
          cnt_nxt = cnt_p0 + CNT_W'(1);
        end
      end
      ST_RUN: begin
        en     = 1'b1;
        inject = 1'b1;
        if ((cnt_p0 + CNT_W'(1)) == nv_p0) begin
          cnt_nxt   = '0;
          state_nxt = ST_DRAIN;
        end else begin
          cnt_nxt = cnt_p0 + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_p0 == DRAIN_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt_p0 + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Valid pipe mirrors the DUT latency; its last stage marks a result to absorb.
  always_comb begin
    vld_nxt    = vld_p0 << 1;
    vld_nxt[0] = inject;
  end

  assign absorb = vld_p0[DUT_LAT-1];

  // Control, valid pipe, vector counter and MISR registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_p0 <= ST_IDLE;
      cnt_p0   <= '0;
      nv_p0    <= '0;
      vld_p0   <= '0;
      vec_p0   <= '0;
      sig_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      vld_p0   <= vld_nxt;
      if (load) begin
        nv_p0  <= bus.num_vectors;
        vec_p0 <= '0;
        sig_p0 <= '0;
      end else if (absorb) begin
        vec_p0 <= vec_p0 + CNT_W'(1);
        sig_p0 <= RES_W'(misr_step(32'(sig_p0), 32'(bus.dut_result), RES_W));
      end
    end
  end

  assign bus.operands  = operands_w;
  assign bus.busy      = (state_p0 == ST_FILL) || (state_p0 == ST_RUN) ||
                         (state_p0 == ST_DRAIN);
  assign bus.done      = (state_p0 == ST_DONE);
  assign bus.vec_cnt   = vec_p0;
  assign bus.signature = sig_p0;

endmodule
